// File: rtl/seq_pm_mult.sv
// seq_pm_mult: sequential signed/unsigned multiplier.
// Each W-bit operand is split into H = W/2 bit halves. One shared HxH unsigned multiplier is
// time-multiplexed over four cycles, and its partial products are accumulated into a 2W-bit
// magnitude. A final cycle applies the result sign.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake; a, b and signed_mode are sampled on acceptance
//   a, b                  W-bit operands
//   signed_mode           1 = two's-complement operands, 0 = unsigned
//   out_valid / out_ready result handshake; p is held stable while out_valid & !out_ready
//   p                     2W-bit product
//   busy                  high whenever the block is not idle
// W must be even and at least 4.
module seq_pm_mult #(
   parameter int unsigned W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] p,
   output logic           busy
);

   localparam int unsigned H = W / 2;
   localparam logic [W-1:0]   OneW  = W'(1);
   localparam logic [2*W-1:0] One2W = (2*W)'(1);

   typedef enum logic [2:0] {
      StIdle,
      StMul0,
      StMul1,
      StMul2,
      StMul3,
      StFix,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     ma_q, ma_d;
   logic [W-1:0]     mb_q, mb_d;
   logic             neg_q, neg_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   p_q, p_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic [W-1:0]     a_mag, b_mag;
   logic [H-1:0]     mul_a, mul_b;
   logic [W-1:0]     prod;
   logic [2*W-1:0]   pp;
   logic [2*W-1:0]   pp_sh;

   // Ready is combinational from out_ready so a new operation can start in the DONE cycle.
   assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign accept   = in_valid & in_ready;

   // The magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
   assign a_mag = (signed_mode & a[W-1]) ? (~a + OneW) : a;
   assign b_mag = (signed_mode & b[W-1]) ? (~b + OneW) : b;

   // Half selection for the shared multiplier: MUL1/MUL3 use the high half of ma,
   // MUL2/MUL3 use the high half of mb.
   assign mul_a = ((state_q == StMul1) || (state_q == StMul3)) ? ma_q[W-1:H] : ma_q[H-1:0];
   assign mul_b = ((state_q == StMul2) || (state_q == StMul3)) ? mb_q[W-1:H] : mb_q[H-1:0];
   assign prod  = {{H{1'b0}}, mul_a} * {{H{1'b0}}, mul_b};
   assign pp    = {{W{1'b0}}, prod};

   always_comb begin
      pp_sh = pp;
      unique case (state_q)
         StMul1, StMul2: pp_sh = pp << H;
         StMul3:         pp_sh = pp << W;
         default:        pp_sh = pp;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      p_d         = p_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         StIdle: state_d = StIdle;
         StMul0: begin
            acc_d   = acc_q + pp_sh;
            state_d = StMul1;
         end
         StMul1: begin
            acc_d   = acc_q + pp_sh;
            state_d = StMul2;
         end
         StMul2: begin
            acc_d   = acc_q + pp_sh;
            state_d = StMul3;
         end
         StMul3: begin
            // Magnitude product < 2^(2W), so acc cannot overflow.
            acc_d   = acc_q + pp_sh;
            state_d = StFix;
         end
         StFix: begin
            p_d         = neg_q ? (~acc_q + One2W) : acc_q;
            out_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Acceptance (from IDLE, or from DONE while the result is taken) overrides the above.
      if (accept) begin
         ma_d    = a_mag;
         mb_d    = b_mag;
         neg_d   = signed_mode & (a[W-1] ^ b[W-1]);
         acc_d   = '0;
         state_d = StMul0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         ma_q        <= '0;
         mb_q        <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         p_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign p         = p_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != StIdle);

endmodule
